light_pen_detector: RTL

- Upstream stage of the LED matrix driver. Converts the raw photodetector output of the light pen into a one-cycle write-enable pulse (`we`).
- The pulse is aligned to the pixel currently addressed by the scan driver, so the display RAM writes exactly that pixel.
- Also reports the last hit pixel as binary row/col indices for the state machine and colour selector.

---
 rtl/light_pen_detector.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/light_pen_detector.sv
// Light pen front end: settles and samples the photodetector per scanned pixel and emits a
// one-cycle write pulse plus the last hit position. Optional feature: LIGHT_PEN_CONFIRM_EN.
module light_pen_detector #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned HIT_CYCLES    = 3,
   parameter int unsigned CNT_W         = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pen_in,
   input  logic       pen_btn,
   input  logic [7:0] led_row,
   input  logic [7:0] led_col,
   output logic       we,
   output logic [2:0] hit_row,
   output logic [2:0] hit_col,
   output logic       hit_valid
);

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned IDX_W  = 3;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HIT_LAST    = CNT_W'(HIT_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_HIT, S_DONE} state_e;

   function automatic logic [IDX_W-1:0] enc8(input logic [7:0] v);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

   state_e             state_q, state_d;
   logic [1:0]         pen_sync_q, btn_sync_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [CNT_W-1:0]   settle_q, settle_d;
   logic [CNT_W-1:0]   hitc_q, hitc_d;
   logic               we_q, we_d;
   logic [IDX_W-1:0]   row_q, row_d, col_q, col_d;
   logic               valid_q, valid_d;
   logic               hif_q, hif_d;
`ifdef LIGHT_PEN_CONFIRM_EN
   logic [2*IDX_W-1:0] prev_q, prev_d;
   logic               conf_q, conf_d;
`endif

   logic              pen_s, btn_s;
   logic              addr_chg, addr_ok, frame_start;
   logic [IDX_W-1:0]  row_idx, col_idx;

   assign pen_s       = pen_sync_q[1];
   assign btn_s       = btn_sync_q[1];
   assign addr_chg    = ({led_row, led_col} != addr_q);
   assign addr_ok     = $onehot(led_row) && $onehot(led_col);
   assign frame_start = addr_chg && (led_row == 8'h01) && (led_col == 8'h01);
   assign row_idx     = enc8(led_row);
   assign col_idx     = enc8(led_col);

   assign we        = we_q;
   assign hit_row   = row_q;
   assign hit_col   = col_q;
   assign hit_valid = valid_q;

   // Next-state, counters and hit bookkeeping; an address change overrides everything.
   always_comb begin
      logic hit_set;
      state_d  = state_q;
      settle_d = settle_q;
      hitc_d   = hitc_q;
      we_d     = 1'b0;
      row_d    = row_q;
      col_d    = col_q;
      valid_d  = valid_q;
      hif_d    = hif_q;
      hit_set  = 1'b0;
`ifdef LIGHT_PEN_CONFIRM_EN
      prev_d   = prev_q;
      conf_d   = conf_q;
`endif
      if (addr_chg) begin
         state_d  = addr_ok ? S_SETTLE : S_IDLE;
         settle_d = '0;
         hitc_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_SETTLE: begin
               if (settle_q == SETTLE_LAST) begin
                  state_d = S_SAMPLE;
                  hitc_d  = '0;
               end else begin
                  settle_d = settle_q + CNT_W'(1);
               end
            end
            S_SAMPLE: begin
               if (!pen_s) begin
                  hitc_d = '0;
               end else if (hitc_q != HIT_LAST) begin
                  hitc_d = hitc_q + CNT_W'(1);
               end else begin
                  state_d = S_DONE;
                  if (btn_s) begin
`ifdef LIGHT_PEN_CONFIRM_EN
                     // Write only when the previous qualified hit was this same pixel.
                     if (conf_q && (prev_q == {row_idx, col_idx})) hit_set = 1'b1;
                     prev_d = {row_idx, col_idx};
                     conf_d = 1'b1;
`else
                     hit_set = 1'b1;
`endif
                  end
               end
            end
            S_HIT:  state_d = S_DONE;
            S_DONE: state_d = S_DONE;
            default: state_d = S_IDLE;
         endcase
      end

      if (hit_set) begin
         state_d = S_HIT;
         we_d    = 1'b1;
         row_d   = row_idx;
         col_d   = col_idx;
      end

      // A frame with no hit drops hit_valid at the next frame start; a concurrent hit wins.
      if (frame_start) begin
         if (!hif_q) valid_d = 1'b0;
         hif_d = 1'b0;
      end
      if (hit_set) begin
         valid_d = 1'b1;
         hif_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pen_sync_q <= '0;
         btn_sync_q <= '0;
         addr_q     <= '0;
         settle_q   <= '0;
         hitc_q     <= '0;
         we_q       <= 1'b0;
         row_q      <= '0;
         col_q      <= '0;
         valid_q    <= 1'b0;
         hif_q      <= 1'b0;
`ifdef LIGHT_PEN_CONFIRM_EN
         prev_q     <= '0;
         conf_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pen_sync_q <= {pen_sync_q[0], pen_in};
         btn_sync_q <= {btn_sync_q[0], pen_btn};
         addr_q     <= {led_row, led_col};
         settle_q   <= settle_d;
         hitc_q     <= hitc_d;
         we_q       <= we_d;
         row_q      <= row_d;
         col_q      <= col_d;
         valid_q    <= valid_d;
         hif_q      <= hif_d;
`ifdef LIGHT_PEN_CONFIRM_EN
         prev_q     <= prev_d;
         conf_q     <= conf_d;
`endif
      end
   end

endmodule
